// File: rtl/itim_assoc.sv
// N-way set-associative instruction cache between fetch and the instruction memory bus.
// Serves halfword-aligned 32-bit fetches and splits line-crossing fetches into two word reads.

module itim_assoc_way #(
  parameter int SETS  = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx0,
  input  logic [IDX_W-1:0] rd_idx1,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  output logic             rd_valid0,
  output logic [TAG_W-1:0] rd_tag0,
  output logic [31:0]      rd_data0,
  output logic             rd_valid1,
  output logic [TAG_W-1:0] rd_tag1,
  output logic [15:0]      rd_data1
);
  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS];

  always_ff @(posedge clock) begin
    if (reset) valid_q <= '0;
    else begin
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
      if (clr_en) valid_q[clr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Second port only ever supplies the low halfword of the crossing word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid0 <= 1'b0;
      rd_tag0   <= '0;
      rd_data0  <= '0;
      rd_valid1 <= 1'b0;
      rd_tag1   <= '0;
      rd_data1  <= '0;
    end else if (rd_en) begin
      rd_valid0 <= valid_q[rd_idx0];
      rd_tag0   <= tag_mem[rd_idx0];
      rd_data0  <= data_mem[rd_idx0];
      rd_valid1 <= valid_q[rd_idx1];
      rd_tag1   <= tag_mem[rd_idx1];
      rd_data1  <= data_mem[rd_idx1][15:0];
    end
  end
endmodule

module itim_assoc #(
  parameter int          ways      = 2,
  parameter int          sets      = 64,
  parameter logic [31:0] base_addr = 32'h0000_0000,
  parameter logic [31:0] top_addr  = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_fence,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(sets);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (ways > 1) ? $clog2(ways) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, BYPASS, FLUSH} state_t;
  state_t state_q, state_d;

  logic [31:0] w0_addr, w1_addr, d0_q, rdata_q;
  logic [15:0] d1_q;
  logic        cross_q, fetch_w1, have1_q, ready_q;
  logic [IDX_W-1:0] flush_idx;
  logic [sets-1:0][WAY_W-1:0] rr_q;

  logic [ways-1:0]             rv0, rv1, way_we;
  logic [ways-1:0][TAG_W-1:0]  rt0, rt1;
  logic [ways-1:0][31:0]       rdd0;
  logic [ways-1:0][15:0]       rdd1;

  logic [31:0] req_w0, req_w1;
  logic        rd_en;
  assign req_w0 = cpu_addr & 32'hFFFF_FFFC;
  assign req_w1 = req_w0 + 32'd4;
  assign rd_en  = (state_q == IDLE) && cpu_valid && !cpu_fence;

  logic [31:0]      cur_addr;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             fill, clr_en;
  assign cur_addr = fetch_w1 ? w1_addr : w0_addr;
  assign wr_idx   = cur_addr[IDX_W+1:2];
  assign wr_tag   = cur_addr[31:IDX_W+2];
  assign clr_en   = (state_q == FLUSH);

  for (genvar w = 0; w < ways; w++) begin : g_way
    itim_assoc_way #(.SETS(sets), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
      .clock    (clock),
      .reset    (reset),
      .rd_en    (rd_en),
      .rd_idx0  (req_w0[IDX_W+1:2]),
      .rd_idx1  (req_w1[IDX_W+1:2]),
      .wr_en    (way_we[w]),
      .wr_idx   (wr_idx),
      .wr_tag   (wr_tag),
      .wr_data  (mem_rdata),
      .clr_en   (clr_en),
      .clr_idx  (flush_idx),
      .rd_valid0(rv0[w]),
      .rd_tag0  (rt0[w]),
      .rd_data0 (rdd0[w]),
      .rd_valid1(rv1[w]),
      .rd_tag1  (rt1[w]),
      .rd_data1 (rdd1[w])
    );
  end

  // Tag compare for both candidate words against the latched request.
  logic        hit0, hit1, comp0, need1, in0, in1, oob, all_hit, lk_hit;
  logic [31:0] hd0, hit_rdata;
  logic [15:0] hd1;
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    hd0  = '0;
    hd1  = '0;
    for (int w = 0; w < ways; w++) begin
      if (rv0[w] && rt0[w] == w0_addr[31:IDX_W+2]) begin
        hit0 = 1'b1;
        hd0  = rdd0[w];
      end
      if (rv1[w] && rt1[w] == w1_addr[31:IDX_W+2]) begin
        hit1 = 1'b1;
        hd1  = rdd1[w];
      end
    end
  end

  // Single unsigned compare per word keeps region checks free of constant compares.
  assign comp0     = hd0[17:16] != 2'b11;
  assign need1     = cross_q && !(hit0 && comp0);
  assign in0       = (w0_addr - base_addr) < (top_addr - base_addr);
  assign in1       = (w1_addr - base_addr) < (top_addr - base_addr);
  assign oob       = !in0 || (need1 && !in1);
  assign all_hit   = hit0 && (!need1 || hit1);
  assign lk_hit    = (state_q == LOOKUP) && !oob && all_hit;
  assign hit_rdata = cross_q ? {(hit1 ? hd1 : 16'h0), hd0[31:16]} : hd0;

  logic mem_done, more, fin, flush_last;
  assign mem_done   = (state_q == REFILL || state_q == BYPASS) && mem_valid && mem_ready;
  assign more       = !fetch_w1 && cross_q && !have1_q && (mem_rdata[17:16] == 2'b11);
  assign fin        = mem_done && !more;
  assign fill       = (state_q == REFILL) && mem_done;
  assign flush_last = flush_idx == IDX_W'(sets - 1);

  // Victim: lowest invalid way of the set being filled, else its round-robin pointer.
  logic [ways-1:0]  vvec;
  logic [WAY_W-1:0] vic;
  always_comb begin
    vvec = fetch_w1 ? rv1 : rv0;
    vic  = rr_q[wr_idx];
    for (int w = ways - 1; w >= 0; w--)
      if (!vvec[w]) vic = WAY_W'(w);
    for (int w = 0; w < ways; w++)
      way_we[w] = fill && (vic == WAY_W'(w));
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (cpu_valid) state_d = cpu_fence ? FLUSH : LOOKUP;
      LOOKUP:         state_d = oob ? BYPASS : (all_hit ? IDLE : REFILL);
      REFILL, BYPASS: if (fin) state_d = IDLE;
      FLUSH:          if (flush_last) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w0_addr    <= '0;
      w1_addr    <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      cross_q    <= 1'b0;
      fetch_w1   <= 1'b0;
      have1_q    <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      flush_idx  <= '0;
      rr_q       <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (cpu_valid) begin
          w0_addr   <= req_w0;
          w1_addr   <= req_w1;
          cross_q   <= cpu_addr[1];
          flush_idx <= '0;
        end
        LOOKUP: begin
          if (oob) begin
            miss_count <= miss_count + 32'd1;
            mem_valid  <= 1'b1;
            mem_addr   <= w0_addr;
            fetch_w1   <= 1'b0;
            have1_q    <= 1'b0;
            d1_q       <= '0;
          end else if (all_hit) begin
            hit_count <= hit_count + 32'd1;
          end else begin
            miss_count <= miss_count + 32'd1;
            mem_valid  <= 1'b1;
            mem_addr   <= hit0 ? w1_addr : w0_addr;
            fetch_w1   <= hit0;
            d0_q       <= hd0;
            have1_q    <= hit1;
            d1_q       <= hit1 ? hd1 : 16'h0;
          end
        end
        REFILL, BYPASS: begin
          if (mem_done) begin
            mem_valid <= 1'b0;
            if (fetch_w1) begin
              ready_q <= 1'b1;
              rdata_q <= {mem_rdata[15:0], d0_q[31:16]};
            end else begin
              d0_q <= mem_rdata;
              if (more) begin
                fetch_w1 <= 1'b1;
                mem_addr <= w1_addr;
              end else begin
                ready_q <= 1'b1;
                rdata_q <= cross_q ? {d1_q, mem_rdata[31:16]} : mem_rdata;
              end
            end
          end else if (!mem_valid) begin
            mem_valid <= 1'b1;
          end
          if (fill) rr_q[wr_idx] <= (ways == 1) ? '0 : WAY_W'(rr_q[wr_idx] + 1'b1);
        end
        FLUSH: begin
          flush_idx <= flush_idx + 1'b1;
          if (flush_last) begin
            ready_q <= 1'b1;
            rdata_q <= '0;
            rr_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready = ready_q | lk_hit;
  assign cpu_rdata = lk_hit ? hit_rdata : (ready_q ? rdata_q : 32'h0);
endmodule
